// File: rtl/lcd_panel_rx.sv
// HD44780-style LCD controller model: receiving end of the parallel LCD bus.
// Captures RS/E/DB through synchronizers, decodes each E falling edge as an
// instruction or a character write, keeps a 2x16 character buffer, and
// enforces a busy window, counting strobes that arrive while busy.
module lcd_panel_rx #(
  parameter int unsigned BUSY_CYC  = 4000,
  parameter int unsigned BUSY_LONG = 164000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       reg_sel_i,
  input  logic       enable_i,
  input  logic [7:0] lcd_data_i,
  input  logic [4:0] rd_addr_i,
  output logic [7:0] rd_data_o,
  output logic       cmd_valid_o,
  output logic [7:0] cmd_o,
  output logic       char_wr_o,
  output logic [6:0] char_addr_o,
  output logic [7:0] char_o,
  output logic [6:0] cur_addr_o,
  output logic       busy_o,
  output logic       disp_on_o,
  output logic       cursor_on_o,
  output logic       blink_o,
  output logic       incr_o,
  output logic       lines2_o,
  output logic [7:0] viol_cnt_o
);

  localparam int unsigned CW = $clog2(BUSY_LONG + 1);

  typedef enum logic [3:0] {
    INS_NOP,
    INS_CLEAR,
    INS_HOME,
    INS_ENTRY,
    INS_DISP,
    INS_SHIFT,
    INS_FUNC,
    INS_CGRAM,
    INS_DDRAM
  } ins_e;

  // Stage 1/2 are the synchronizer; stage 3 holds the previous E sample and
  // the RS/data that travelled with it.
  logic       e_q1, e_q2, e_q3;
  logic       rs_q1, rs_q2, rs_q3;
  logic [7:0] d_q1, d_q2, d_q3;

  logic [CW-1:0] busy_cnt;
  logic [7:0]    mem [32];

  logic       strobe;
  logic       accept;
  logic       drop;
  logic       long_op;
  logic [4:0] wr_idx;
  ins_e       ins;

  // Next visible DDRAM address, wrapping line 1 <-> line 2 in both directions.
  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic up);
    logic [6:0] r;
    r = a;
    if (up) begin
      case (a)
        7'h0F:   r = 7'h40;
        7'h4F:   r = 7'h00;
        default: r = a + 7'd1;
      endcase
    end else begin
      case (a)
        7'h00:   r = 7'h4F;
        7'h40:   r = 7'h0F;
        default: r = a - 7'd1;
      endcase
    end
    return r;
  endfunction

  // Input synchronizers, RS/data kept in lockstep with E.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      e_q1  <= 1'b0;
      e_q2  <= 1'b0;
      e_q3  <= 1'b0;
      rs_q1 <= 1'b0;
      rs_q2 <= 1'b0;
      rs_q3 <= 1'b0;
      d_q1  <= '0;
      d_q2  <= '0;
      d_q3  <= '0;
    end else begin
      e_q1  <= enable_i;
      e_q2  <= e_q1;
      e_q3  <= e_q2;
      rs_q1 <= reg_sel_i;
      rs_q2 <= rs_q1;
      rs_q3 <= rs_q2;
      d_q1  <= lcd_data_i;
      d_q2  <= d_q1;
      d_q3  <= d_q2;
    end
  end

  assign strobe = e_q3 & ~e_q2;
  assign busy_o = (busy_cnt != '0);
  assign accept = strobe & ~busy_o;
  assign drop   = strobe & busy_o;
  assign wr_idx = {cur_addr_o[6], cur_addr_o[3:0]};

  // Instruction class: highest set bit of the captured byte wins.
  always_comb begin
    ins = INS_NOP;
    if      (d_q3[7]) ins = INS_DDRAM;
    else if (d_q3[6]) ins = INS_CGRAM;
    else if (d_q3[5]) ins = INS_FUNC;
    else if (d_q3[4]) ins = INS_SHIFT;
    else if (d_q3[3]) ins = INS_DISP;
    else if (d_q3[2]) ins = INS_ENTRY;
    else if (d_q3[1]) ins = INS_HOME;
    else if (d_q3[0]) ins = INS_CLEAR;
    long_op = ~rs_q3 & ((ins == INS_CLEAR) | (ins == INS_HOME));
  end

  // Controller state: busy window, violations, buffer, address and flags.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      busy_cnt    <= '0;
      viol_cnt_o  <= '0;
      cmd_valid_o <= 1'b0;
      cmd_o       <= '0;
      char_wr_o   <= 1'b0;
      char_addr_o <= '0;
      char_o      <= '0;
      cur_addr_o  <= '0;
      disp_on_o   <= 1'b0;
      cursor_on_o <= 1'b0;
      blink_o     <= 1'b0;
      incr_o      <= 1'b1;
      lines2_o    <= 1'b0;
      for (int unsigned i = 0; i < 32; i++) mem[i] <= 8'h20;
    end else begin
      cmd_valid_o <= 1'b0;
      char_wr_o   <= 1'b0;
      if (busy_o) busy_cnt <= busy_cnt - CW'(1);
      if (drop && viol_cnt_o != 8'hFF) viol_cnt_o <= viol_cnt_o + 8'd1;
      if (accept) begin
        busy_cnt <= long_op ? CW'(BUSY_LONG) : CW'(BUSY_CYC);
        if (rs_q3) begin
          mem[wr_idx] <= d_q3;
          char_wr_o   <= 1'b1;
          char_addr_o <= cur_addr_o;
          char_o      <= d_q3;
          cur_addr_o  <= step_addr(cur_addr_o, incr_o);
        end else begin
          cmd_valid_o <= 1'b1;
          cmd_o       <= d_q3;
          case (ins)
            INS_DDRAM: cur_addr_o <= {d_q3[6], 2'b00, d_q3[3:0]};
            INS_FUNC:  lines2_o <= d_q3[3];
            INS_SHIFT: if (!d_q3[3]) cur_addr_o <= step_addr(cur_addr_o, d_q3[2]);
            INS_DISP: begin
              disp_on_o   <= d_q3[2];
              cursor_on_o <= d_q3[1];
              blink_o     <= d_q3[0];
            end
            INS_ENTRY: incr_o <= d_q3[1];
            INS_HOME:  cur_addr_o <= '0;
            INS_CLEAR: begin
              for (int unsigned i = 0; i < 32; i++) mem[i] <= 8'h20;
              cur_addr_o <= '0;
              incr_o     <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Registered readback; a same-cycle write is seen one cycle later.
  always_ff @(posedge clk_i) begin
    rd_data_o <= mem[rd_addr_i];
  end

endmodule

// File: tb/tb_lcd_panel_rx.sv
// Bench for lcd_panel_rx: directed bus strobes, a behavioural controller
// model compared every cycle, and hand-computed literal expectations.
module tb_lcd_panel_rx;

  localparam int BC = 20;
  localparam int BL = 60;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       reg_sel = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] data = '0;
  logic [4:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       cmd_valid;
  logic [7:0] cmd;
  logic       char_wr;
  logic [6:0] char_addr;
  logic [7:0] char_v;
  logic [6:0] cur_addr;
  logic       busy;
  logic       disp_on, cursor_on, blink, incr, lines2;
  logic [7:0] viol_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  lcd_panel_rx #(.BUSY_CYC(BC), .BUSY_LONG(BL)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .reg_sel_i(reg_sel), .enable_i(enable),
    .lcd_data_i(data), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .cmd_valid_o(cmd_valid), .cmd_o(cmd), .char_wr_o(char_wr),
    .char_addr_o(char_addr), .char_o(char_v), .cur_addr_o(cur_addr),
    .busy_o(busy), .disp_on_o(disp_on), .cursor_on_o(cursor_on),
    .blink_o(blink), .incr_o(incr), .lines2_o(lines2), .viol_cnt_o(viol_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Buffer is a 32-entry linear array: position = line*16 + column.
  logic [7:0] mbuf [32];
  int         m_busy;
  logic [6:0] m_cur, m_char_addr;
  logic       m_disp, m_curs, m_blink, m_incr, m_lines2, m_cmdv, m_charwr;
  logic [7:0] m_viol, m_cmd, m_char;
  logic       h_e [4];
  logic       h_rs [4];
  logic [7:0] h_d [4];
  bit         model_valid = 1'b0;

  function automatic int addr2pos(input logic [6:0] a);
    return (a[6] ? 16 : 0) + int'(a[3:0]);
  endfunction

  function automatic logic [6:0] pos2addr(input int p);
    return {p[4], 2'b00, p[3:0]};
  endfunction

  function automatic logic [6:0] move(input logic [6:0] a, input logic up);
    int p;
    p = addr2pos(a);
    p = up ? (p + 1) % 32 : (p + 31) % 32;
    return pos2addr(p);
  endfunction

  // Each bus fall seen at input edge k takes effect at edge k+2.
  always @(posedge clk) begin : model_cmp
    logic       s_rst, s_e, s_rs, ev, rd_ok, lng;
    logic [7:0] s_d, d, exp_rd;
    logic [4:0] s_rda;
    s_rst = rst_n; s_e = enable; s_rs = reg_sel; s_d = data; s_rda = rd_addr;
    #1;
    exp_rd = mbuf[s_rda];
    rd_ok  = model_valid;
    m_cmdv = 1'b0;
    m_charwr = 1'b0;
    for (int i = 3; i > 0; i--) begin
      h_e[i] = h_e[i-1]; h_rs[i] = h_rs[i-1]; h_d[i] = h_d[i-1];
    end
    h_e[0] = s_e; h_rs[0] = s_rs; h_d[0] = s_d;
    if (!s_rst) begin
      for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
      for (int i = 0; i < 4; i++) h_e[i] = 1'b0;
      m_busy = 0; m_cur = '0; m_char_addr = '0; m_disp = 0; m_curs = 0;
      m_blink = 0; m_incr = 1; m_lines2 = 0; m_viol = '0; m_cmd = '0; m_char = '0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      ev = h_e[3] && !h_e[2];
      d  = h_d[3];
      if (ev && m_busy > 0) begin
        if (m_viol != 8'd255) m_viol = m_viol + 8'd1;
        m_busy--;
      end else if (ev) begin
        lng = 1'b0;
        if (h_rs[3]) begin
          mbuf[addr2pos(m_cur)] = d;
          m_charwr = 1'b1; m_char_addr = m_cur; m_char = d;
          m_cur = move(m_cur, m_incr);
        end else begin
          m_cmdv = 1'b1; m_cmd = d;
          if (d >= 8'h80) m_cur = {d[6], 2'b00, d[3:0]};
          else if (d >= 8'h40) ;
          else if (d >= 8'h20) m_lines2 = d[3];
          else if (d >= 8'h10) begin
            if (!d[3]) m_cur = move(m_cur, d[2]);
          end
          else if (d >= 8'h08) begin m_disp = d[2]; m_curs = d[1]; m_blink = d[0]; end
          else if (d >= 8'h04) m_incr = d[1];
          else if (d >= 8'h02) begin m_cur = '0; lng = 1'b1; end
          else if (d == 8'h01) begin
            for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
            m_cur = '0; m_incr = 1'b1; lng = 1'b1;
          end
        end
        m_busy = lng ? BL : BC;
      end else if (m_busy > 0) begin
        m_busy--;
      end
    end
    if (model_valid) begin
      check("busy", busy, m_busy > 0);
      check("cur_addr", cur_addr, m_cur);
      check("cmd_valid", cmd_valid, m_cmdv);
      check("cmd", cmd, m_cmd);
      check("char_wr", char_wr, m_charwr);
      check("char_addr", char_addr, m_char_addr);
      check("char", char_v, m_char);
      check("flags", {disp_on, cursor_on, blink, incr, lines2},
            {m_disp, m_curs, m_blink, m_incr, m_lines2});
      check("viol_cnt", viol_cnt, m_viol);
    end
    if (rd_ok) check("rd_data", rd_data, exp_rd);
  end

  // ---------------- stimulus ----------------
  task automatic strobe(input logic rs, input logic [7:0] d);
    @(negedge clk);
    reg_sel = rs; data = d; enable = 1'b1;
    repeat (3) @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic wait_idle(output int hi, output int ncmd, output int nchar);
    bit done;
    hi = 0; ncmd = 0; nchar = 0; done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (cmd_valid) ncmd++;
      if (char_wr) nchar++;
      if (busy) hi++;
      else if (hi > 0) done = 1;
    end
    check("busy_window_ends", done, 1'b1);
  endtask

  task automatic send(input logic rs, input logic [7:0] d);
    int hi, nc, nw;
    strobe(rs, d);
    wait_idle(hi, nc, nw);
  endtask

  task automatic read_lit(input logic [4:0] idx, input logic [7:0] exp);
    @(negedge clk);
    rd_addr = idx;
    @(negedge clk);
    check("rd_literal", rd_data, exp);
  endtask

  task automatic sweep();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rd_addr = 5'(i);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int hi, nc, nw;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    sweep();
    check("reset_busy", busy, 1'b0);
    check("reset_incr", incr, 1'b1);
    check("reset_viol", viol_cnt, 8'd0);
    read_lit(5'd31, 8'h20);

    strobe(1'b0, 8'h0F);
    wait_idle(hi, nc, nw);
    check("busy_len_0F", hi, BC);
    check("cmd_pulses_0F", nc, 1);
    strobe(1'b0, 8'h38);
    wait_idle(hi, nc, nw);
    check("busy_len_38", hi, BC);
    check("cmd_pulses_38", nc, 1);
    check("dcb_lines2", {disp_on, cursor_on, blink, lines2}, 4'b1111);

    send(1'b0, 8'h80);
    strobe(1'b1, 8'h41);
    wait_idle(hi, nc, nw);
    check("char_pulses_A", nw, 1);
    check("char_addr_A", char_addr, 7'h00);
    check("cur_after_A", cur_addr, 7'h01);
    read_lit(5'd0, 8'h41);

    send(1'b0, 8'h8F);
    send(1'b1, 8'h42);
    check("wrap_up", cur_addr, 7'h40);
    send(1'b0, 8'h04);
    check("entry_decr", incr, 1'b0);
    send(1'b1, 8'h43);
    check("char_addr_43", char_addr, 7'h40);
    check("wrap_down", cur_addr, 7'h0F);
    read_lit(5'd16, 8'h43);
    read_lit(5'd15, 8'h42);

    strobe(1'b0, 8'h02);
    wait_idle(hi, nc, nw);
    check("busy_len_home", hi, BL);
    check("home_addr", cur_addr, 7'h00);

    send(1'b0, 8'h14);
    check("shift_right", cur_addr, 7'h01);
    send(1'b0, 8'h10);
    send(1'b0, 8'h10);
    check("shift_left_wrap", cur_addr, 7'h4F);
    send(1'b0, 8'h18);
    check("display_shift_hold", cur_addr, 7'h4F);

    strobe(1'b0, 8'h01);
    repeat (7) @(negedge clk);
    strobe(1'b1, 8'h55);
    wait_idle(hi, nc, nw);
    check("dropped_no_write", nw, 0);
    check("viol_one", viol_cnt, 8'd1);
    check("clear_incr", incr, 1'b1);
    check("clear_addr", cur_addr, 7'h00);
    sweep();
    read_lit(5'd0, 8'h20);

    send(1'b1, 8'h5A);
    strobe(1'b1, 8'h5B);
    repeat (5) @(negedge clk);
    check("busy_before_reset", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_flags", {disp_on, cursor_on, blink, incr, lines2}, 5'b00010);
    check("rst_viol", viol_cnt, 8'd0);
    check("rst_addr", cur_addr, 7'h00);
    rst_n = 1'b1;
    sweep();
    read_lit(5'd0, 8'h20);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lcd_panel_rx.md
Name: lcd_panel_rx

Overview:
- Receiving end of the LCD parallel bus driven by lcd_drv_top: an HD44780-style controller model.
- Samples register select, enable strobe and the 8-bit data bus, and decodes each strobe as an instruction or a character write.
- Maintains a 2x16 character buffer, cursor address and display flags; enforces a busy window and counts protocol violations.
- Used as the synthesizable bus partner in top-level simulation and on-board loopback checking.

Parameters:
- BUSY_CYC, 4000, busy cycles after a normal instruction or data write (40 us at 100 MHz).
- BUSY_LONG, 164000, busy cycles after clear display or return home (1.64 ms at 100 MHz).

Ports:
- clk_i  input  1  system clock
- rst_n_i  input  1  synchronous active-low reset
- reg_sel_i  input  1  RS: 0 = instruction, 1 = data
- enable_i  input  1  E strobe; bus captured on its falling edge
- lcd_data_i  input  8  data/instruction bus
- rd_addr_i  input  5  buffer readback index (bit 4 = line, bits 3:0 = column)
- rd_data_o  output  8  buffer readback, 1-cycle latency
- cmd_valid_o  output  1  1-cycle pulse per accepted instruction
- cmd_o  output  8  last accepted instruction byte
- char_wr_o  output  1  1-cycle pulse per accepted buffer write
- char_addr_o  output  7  DDRAM address of the last write
- char_o  output  8  last written character
- cur_addr_o  output  7  current DDRAM address counter
- busy_o  output  1  busy window active
- disp_on_o, cursor_on_o, blink_o  output  1 each  display control flags
- incr_o  output  1  entry mode increment (1) / decrement (0)
- lines2_o  output  1  function set N bit
- viol_cnt_o  output  8  saturating count of strobes received while busy

Behaviour:
- Reset, when rst_n_i = 0 at a clk_i edge:
  - All outputs 0, except incr_o = 1 and rd_data_o = buffer content.
  - Buffer is filled with 0x20 (space).
  - Busy counter is cleared.
  - Reset dominates every other event, including a strobe or an active busy window.
- Input capture:
  - enable_i, reg_sel_i and lcd_data_i each pass through a 2-flop synchronizer, kept aligned.
  - Falling edge = synchronized E 1 -> 0; the RS/data sampled together with the last E = 1 stage are taken.
  - The edge is detected in cycle N; the effect (pulses, register updates) is visible in cycle N+1.
- Busy:
  - A counter loads at N+1 on every accepted strobe: BUSY_LONG for 0x01/0x02, otherwise BUSY_CYC.
  - busy_o = (counter != 0); the counter decrements to 0.
  - A strobe while busy_o = 1 is dropped: no state change, no pulse, viol_cnt_o increments and saturates at 255.
- Instruction decode (RS = 0), highest set bit wins:
  - 1xxxxxxx, set DDRAM address: cur_addr_o = {d[6], 2'b00, d[3:0]}.
  - 001xxxxx, function set: lines2_o = d[3].
  - 0001xxxx, cursor/display shift: accepted, only the address moves; if d[3] = 0, cursor steps +1 when d[2] = 1, else -1.
  - 00001DCB, display control: disp_on_o = D, cursor_on_o = C, blink_o = B.
  - 000001Ix, entry mode: incr_o = I; the display-shift bit is ignored.
  - 0000001x, return home: cur_addr_o = 0.
  - 00000001, clear display: all 32 entries = 0x20, cur_addr_o = 0, incr_o = 1.
  - 00000000: accepted as a no-op.
  - Every accepted instruction pulses cmd_valid_o and latches cmd_o.
- Data write (RS = 1):
  - buffer[{cur_addr[6], cur_addr[3:0]}] = data.
  - char_wr_o pulses; char_addr_o = pre-write address; char_o = data.
  - The address then steps per incr_o.
- Address stepping, visible ranges only:
  - Increment: 0x00..0x0F, 0x0F -> 0x40, 0x40..0x4F, 0x4F -> 0x00.
  - Decrement is the exact reverse: 0x00 -> 0x4F, 0x40 -> 0x0F.
- Readback: rd_data_o is registered from buffer[rd_addr_i]. A write and a read to the same index in the same cycle return the old value.

Test Plan:
- Reset, then read all 32 indices -> each reads 0x20; busy_o = 0, incr_o = 1, viol_cnt_o = 0.
- Instruction 0x0F, then after busy clears 0x38 -> disp_on/cursor_on/blink = 1, lines2_o = 1, two cmd_valid_o pulses, busy_o high exactly BUSY_CYC cycles each.
- 0x80 then "A" (0x41) -> char_wr_o pulse with char_addr_o = 0x00, buffer[0] = 0x41, cur_addr_o = 0x01.
- 0x8F, write 0x42 -> cur_addr_o = 0x40. Then 0x04 (decrement), write 0x43 at 0x40 -> cur_addr_o = 0x0F (wrap both directions).
- 0x01, then a data strobe 10 cycles later -> strobe dropped, viol_cnt_o = 1, buffer all 0x20, busy_o high BUSY_LONG cycles.
- Assert rst_n_i low mid-busy after writes -> next cycle busy_o = 0, buffer cleared to 0x20, all flags reset.
